// File: rtl/mipsfpga_ahb_timer_bank_if.sv
`default_nettype none
// ============================================================================
// mipsfpga_ahb_timer_bank_if : simple peripheral bus behind the AHB-lite decoder
// Revision: 1.0
// ============================================================================
interface mipsfpga_ahb_timer_bank_if;
    logic        sel;
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output sel, output we, output addr, output wdata, input rdata);
    modport slave  (input sel, input we, input addr, input wdata, output rdata);
endinterface
`default_nettype wire

// File: rtl/mipsfpga_ahb_timer_bank.sv
`default_nettype none
// ============================================================================
// mipsfpga_ahb_timer_bank : prescaled free-running TICKS counter plus NCH
// compare channels (one-shot / periodic) with per-channel interrupts.
// Revision: 1.0
// ============================================================================
module mipsfpga_ahb_timer_bank #(
    parameter int CLK_HZ  = 50000000,
    parameter int TICK_HZ = 1000,
    parameter int NCH     = 4
) (
    input  wire logic                 clk,
    input  wire logic                 resetn,
    mipsfpga_ahb_timer_bank_if.slave  bus,
    output logic [31:0]               ticks,
    output logic                      tick_pulse,
    output logic [NCH-1:0]            irq
);
    localparam int PERIOD = CLK_HZ / TICK_HZ;
    localparam int PW     = $clog2(PERIOD);

    logic [PW-1:0]  presc_q, presc_d;
    logic [31:0]    ticks_q, ticks_d;
    logic           run_q, run_d;
    logic           tick_pulse_q, tick_pulse_d;
    logic [31:0]    rdata_q, rdata_d;
    logic [31:0]    cmp_q    [NCH];
    logic [31:0]    cmp_d    [NCH];
    logic [31:0]    reload_q [NCH];
    logic [31:0]    reload_d [NCH];
    logic [NCH-1:0] en_q, en_d, per_q, per_d, ie_q, ie_d, pend_q, pend_d;

    logic           wr, rd, tick_edge, ticks_wr, ctrl_wr;
    logic [3:0]     a_hi;
    logic [1:0]     a_off;
    logic [NCH-1:0] match;
    logic [31:0]    rd_val;
    logic           unused_addr;

    assign unused_addr = ^bus.addr[1:0];

    always_comb begin
        wr        = bus.sel & bus.we;
        rd        = bus.sel & ~bus.we;
        a_hi      = bus.addr[7:4];
        a_off     = bus.addr[3:2];
        tick_edge = run_q && (presc_q == PW'(PERIOD - 1));
        ticks_wr  = wr && (bus.addr[7:2] == 6'h00);
        ctrl_wr   = wr && (bus.addr[7:2] == 6'h01);

        presc_d      = presc_q;
        ticks_d      = ticks_q;
        run_d        = run_q;
        tick_pulse_d = 1'b0;
        cmp_d        = cmp_q;
        reload_d     = reload_q;
        en_d         = en_q;
        per_d        = per_q;
        ie_d         = ie_q;
        pend_d       = pend_q;
        match        = '0;
        rd_val       = '0;

        // A bus write to TICKS pre-empts the tick on the same edge.
        if (ticks_wr) begin
            ticks_d = bus.wdata;
            presc_d = '0;
        end else if (run_q) begin
            if (tick_edge) begin
                presc_d      = '0;
                ticks_d      = ticks_q + 32'd1;
                tick_pulse_d = 1'b1;
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
        if (ctrl_wr) begin
            run_d = bus.wdata[0];
        end

        case (bus.addr[7:2])
            6'h00:   rd_val = ticks_q;
            6'h01:   rd_val = {31'b0, run_q};
            default: ;
        endcase

        // Match first, then bus writes, so written CMP/EN override reload/clear.
        for (int c = 0; c < NCH; c++) begin
            match[c] = tick_edge && !ticks_wr && en_q[c] && ((ticks_q + 32'd1) == cmp_q[c]);
            if (match[c]) begin
                pend_d[c] = 1'b1;
                if (per_q[c]) begin
                    cmp_d[c] = cmp_q[c] + reload_q[c];
                end else begin
                    en_d[c] = 1'b0;
                end
            end
            if (wr && (a_hi == 4'(c + 1))) begin
                case (a_off)
                    2'd0: cmp_d[c]    = bus.wdata;
                    2'd1: reload_d[c] = bus.wdata;
                    2'd2: begin
                        en_d[c]  = bus.wdata[0];
                        per_d[c] = bus.wdata[1];
                        ie_d[c]  = bus.wdata[2];
                        if (bus.wdata[3] && !match[c]) begin
                            pend_d[c] = 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
            if (a_hi == 4'(c + 1)) begin
                case (a_off)
                    2'd0:    rd_val = cmp_q[c];
                    2'd1:    rd_val = reload_q[c];
                    2'd2:    rd_val = {28'b0, pend_q[c], ie_q[c], per_q[c], en_q[c]};
                    default: ;
                endcase
            end
        end

        rdata_d = rd ? rd_val : rdata_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            presc_q      <= '0;
            ticks_q      <= '0;
            run_q        <= 1'b1;
            tick_pulse_q <= 1'b0;
            rdata_q      <= '0;
            en_q         <= '0;
            per_q        <= '0;
            ie_q         <= '0;
            pend_q       <= '0;
            for (int c = 0; c < NCH; c++) begin
                cmp_q[c]    <= '0;
                reload_q[c] <= '0;
            end
        end else begin
            presc_q      <= presc_d;
            ticks_q      <= ticks_d;
            run_q        <= run_d;
            tick_pulse_q <= tick_pulse_d;
            rdata_q      <= rdata_d;
            en_q         <= en_d;
            per_q        <= per_d;
            ie_q         <= ie_d;
            pend_q       <= pend_d;
            cmp_q        <= cmp_d;
            reload_q     <= reload_d;
        end
    end

    assign ticks      = ticks_q;
    assign tick_pulse = tick_pulse_q;
    assign irq        = pend_q & ie_q;
    assign bus.rdata  = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mipsfpga_ahb_timer_bank.sv
`default_nettype none
// ============================================================================
// tb_mipsfpga_ahb_timer_bank : directed scoreboard bench, PERIOD = 10 cycles.
// Revision: 1.0
// ============================================================================
module tb_mipsfpga_ahb_timer_bank;
    localparam int K_TICKS = 0;
    localparam int K_IRQ   = 1;
    localparam int K_PULSE = 2;
    localparam int K_RDATA = 3;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] ticks;
    logic        tick_pulse;
    logic [3:0]  irq;

    mipsfpga_ahb_timer_bank_if bus();

    mipsfpga_ahb_timer_bank #(.CLK_HZ(1000), .TICK_HZ(100), .NCH(4)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .bus        (bus),
        .ticks      (ticks),
        .tick_pulse (tick_pulse),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        logic [31:0] exp;
        string       name;
    } probe_t;

    probe_t      probe_q[$];
    logic [31:0] rd_q[$];
    string       rd_name_q[$];
    int          n_vec = 0;
    int          n_bad = 0;
    logic        rd_valid = 1'b0;
    logic [31:0] rd_exp;
    string       rd_nm;
    probe_t      pr;
    logic [31:0] pr_act;

    always @(posedge clk) rd_valid <= bus.sel & ~bus.we;

    // Read-data monitor: rdata is presented the cycle after a sampled read.
    always @(posedge clk) begin
        #1;
        if (rd_valid) begin
            n_vec++;
            if (rd_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_read: rdata=%08h with nothing expected", bus.rdata);
            end else begin
                rd_exp = rd_q.pop_front();
                rd_nm  = rd_name_q.pop_front();
                if (bus.rdata !== rd_exp) begin
                    n_bad++;
                    $display("FAIL %s: rdata=%08h expected=%08h", rd_nm, bus.rdata, rd_exp);
                end
            end
        end
    end

    // Port monitor: checks every queued probe against the settled outputs.
    always @(negedge clk) begin
        #2;
        while (probe_q.size() > 0) begin
            pr = probe_q.pop_front();
            case (pr.kind)
                K_TICKS: pr_act = ticks;
                K_IRQ:   pr_act = {28'b0, irq};
                K_PULSE: pr_act = {31'b0, tick_pulse};
                default: pr_act = bus.rdata;
            endcase
            n_vec++;
            if (pr_act !== pr.exp) begin
                n_bad++;
                $display("FAIL %s: got=%08h expected=%08h", pr.name, pr_act, pr.exp);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        bus.sel = 1'b1; bus.we = 1'b1; bus.addr = a; bus.wdata = d;
        @(negedge clk);
        bus.sel = 1'b0; bus.we = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, input logic [31:0] e, input string nm);
        bus.sel = 1'b1; bus.we = 1'b0; bus.addr = a;
        rd_q.push_back(e);
        rd_name_q.push_back(nm);
        @(negedge clk);
        bus.sel = 1'b0;
    endtask

    task automatic probe(input int k, input logic [31:0] e, input string nm);
        probe_t p;
        p.kind = k; p.exp = e; p.name = nm;
        probe_q.push_back(p);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.sel = 1'b0; bus.we = 1'b0; bus.addr = 8'h00; bus.wdata = 32'h0;
        resetn = 1'b0;
        step(3);
        probe(K_TICKS, 32'h0, "rst_ticks");
        probe(K_IRQ,   32'h0, "rst_irq");
        probe(K_PULSE, 32'h0, "rst_tick_pulse");
        probe(K_RDATA, 32'h0, "rst_rdata");
        step(1);
        resetn = 1'b1;

        // Idle: tick_pulse only in cycles 10, 20, 30 after release.
        for (int k = 1; k <= 35; k++) begin
            step(1);
            probe(K_PULSE, (k % 10 == 0) ? 32'h1 : 32'h0, $sformatf("tick_pulse_c%0d", k));
        end
        probe(K_TICKS, 32'd3, "idle_ticks");
        probe(K_IRQ,   32'h0, "idle_irq");
        rd(8'h04, 32'h1, "ctrl_reset_run");
        rd(8'h7C, 32'h0, "unmapped_7c");
        rd(8'hF0, 32'h0, "unmapped_f0");
        rd(8'h50, 32'h0, "absent_channel");

        // TICKS wrap.
        wr(8'h00, 32'hFFFF_FFFE);
        step(9);  probe(K_TICKS, 32'hFFFF_FFFE, "wrap_pre");
        step(1);  probe(K_TICKS, 32'hFFFF_FFFF, "wrap_max");
        rd(8'h00, 32'hFFFF_FFFF, "wrap_read");
        step(8);  probe(K_TICKS, 32'hFFFF_FFFF, "wrap_hold");
        step(1);  probe(K_TICKS, 32'h0, "wrap_zero");
        probe(K_IRQ, 32'h0, "wrap_irq");

        // ch0 one-shot at 5.
        wr(8'h00, 32'h0);
        wr(8'h10, 32'd5);
        wr(8'h18, 32'h5);
        step(47); probe(K_IRQ, 32'h0, "os_irq_before"); probe(K_TICKS, 32'd4, "os_ticks_before");
        step(1);  probe(K_IRQ, 32'h1, "os_irq_rise");   probe(K_TICKS, 32'd5, "os_ticks_at");
        rd(8'h18, 32'hC, "os_cfg_en_cleared");
        wr(8'h18, 32'hC);
        probe(K_IRQ, 32'h0, "os_w1c");
        step(60); probe(K_IRQ, 32'h0, "os_no_second");
        rd(8'h18, 32'h4, "os_cfg_after");

        // ch1 periodic: 4, 7, 10, 13.
        wr(8'h00, 32'h0);
        wr(8'h20, 32'd4);
        wr(8'h24, 32'd3);
        wr(8'h28, 32'h7);
        step(36); probe(K_IRQ, 32'h0, "per_before_4");
        step(1);  probe(K_IRQ, 32'h2, "per_match_4"); probe(K_TICKS, 32'd4, "per_ticks_4");
        wr(8'h28, 32'hF); probe(K_IRQ, 32'h0, "per_w1c_4");
        step(28); probe(K_IRQ, 32'h0, "per_before_7");
        step(1);  probe(K_IRQ, 32'h2, "per_match_7");
        wr(8'h28, 32'hF);
        step(28); probe(K_IRQ, 32'h0, "per_before_10");
        step(1);  probe(K_IRQ, 32'h2, "per_match_10"); probe(K_TICKS, 32'd10, "per_ticks_10");
        rd(8'h20, 32'd13, "per_cmp_13");
        wr(8'h28, 32'hF); probe(K_IRQ, 32'h0, "per_w1c_10");
        step(27); probe(K_IRQ, 32'h0, "per_before_13");
        wr(8'h28, 32'hF);
        probe(K_IRQ, 32'h2, "w1c_vs_match"); probe(K_TICKS, 32'd13, "per_ticks_13");
        rd(8'h20, 32'd16, "per_cmp_16");
        wr(8'h28, 32'h8); probe(K_IRQ, 32'h0, "per_disable");

        // RUN=0 freezes counting.
        wr(8'h04, 32'h0);
        probe(K_TICKS, 32'd13, "run0_start");
        step(50);
        probe(K_TICKS, 32'd13, "run0_frozen");
        probe(K_PULSE, 32'h0, "run0_no_pulse");
        rd(8'h04, 32'h0, "ctrl_run0");
        wr(8'h04, 32'h1);

        // Asynchronous reset with an interrupt pending.
        wr(8'h00, 32'h0);
        wr(8'h10, 32'd1);
        wr(8'h18, 32'h5);
        step(8);  probe(K_IRQ, 32'h1, "pre_reset_irq");
        step(3);
        resetn = 1'b0;
        probe(K_TICKS, 32'h0, "async_rst_ticks");
        probe(K_IRQ,   32'h0, "async_rst_irq");
        step(2);
        resetn = 1'b1;
        rd(8'h04, 32'h1, "ctrl_after_mid_reset");
        rd(8'h18, 32'h0, "cfg_after_mid_reset");
        probe(K_TICKS, 32'h0, "ticks_after_mid_reset");

        for (int i = 0; i < 20 && (rd_q.size() + probe_q.size()) > 0; i++) step(1);
        if ((rd_q.size() + probe_q.size()) > 0) begin
            n_bad += rd_q.size() + probe_q.size();
            $display("FAIL drain: %0d reads and %0d probes left, required 0", rd_q.size(), probe_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
